seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/div_pkg.sv | 13 +
 rtl/div_step.sv | 27 ++
 rtl/seq_divider.sv | 135 +++++++++++++
 tb/tb_seq_divider.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
// Holds the FSM state enum and the default operand width.
package div_pkg;

  localparam int DIV_N = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift, compare, subtract.
// rem_i/rem_o: partial remainder (N+1b); bit_i: next dividend bit;
// div_i: divisor (N b); q_o: quotient bit produced this step.
module div_step
  import div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic [N:0]   rem_i,
  input  logic         bit_i,
  input  logic [N-1:0] div_i,
  output logic [N:0]   rem_o,
  output logic         q_o
);

  logic [N+1:0] sh;
  logic [N:0]   diff;

  always_comb begin
    sh    = {rem_i, bit_i};
    q_o   = (sh >= {2'b00, div_i});
    // Only used when sh >= div_i, so the top bit is always zero then.
    diff  = sh[N:0] - {1'b0, div_i};
    rem_o = q_o ? diff : sh[N:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned divider, 2N-bit dividend / N-bit divisor.
// Ports: clk, rst (sync, active-high), ea/eb load enables,
// data_a (2N), data_b (N), start; q_out, r_out, busy, done, ovf.
// Macro DIV_OVF_CHECK_EN: detect overflow at start, finish at once.
module seq_divider
  import div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ea,
  input  logic           eb,
  input  logic [2*N-1:0] data_a,
  input  logic [N-1:0]   data_b,
  input  logic           start,
  output logic [N-1:0]   q_out,
  output logic [N-1:0]   r_out,
  output logic           busy,
  output logic           done,
  output logic           ovf
);

  localparam int CW = $clog2(N) + 1;

  state_e         state_q, state_d;
  logic [2*N-1:0] reg_a_q, reg_a_d;
  logic [N-1:0]   reg_b_q, reg_b_d;
  logic [N:0]     rem_q, rem_d;
  logic [N-1:0]   lo_q, lo_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   q_q, q_d;
  logic [N-1:0]   r_q, r_d;
  logic           ovf_q, ovf_d;

  logic [N:0]     step_rem;
  logic           step_q;
  logic [N:0]     lo_sh;
  logic           big;

`ifdef DIV_OVF_CHECK_EN
  assign big = (reg_a_q[2*N-1:N] >= reg_b_q);
`else
  assign big = 1'b0;
`endif

  // lo_q shifts dividend bits out at the top and quotient bits in
  // at the bottom, so it holds the quotient after N steps.
  div_step #(.N(N)) u_step (
    .rem_i (rem_q),
    .bit_i (lo_q[N-1]),
    .div_i (reg_b_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  assign lo_sh = {lo_q, step_q};

  always_comb begin
    state_d = state_q;
    reg_a_d = reg_a_q;
    reg_b_d = reg_b_q;
    rem_d   = rem_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (ea) reg_a_d = data_a;
        if (eb) reg_b_d = data_b;
        // Operands come from the registers before this edge's load.
        if (start) begin
          if (big) begin
            state_d = DONE;
            q_d     = '1;
            r_d     = '0;
            ovf_d   = 1'b1;
          end else begin
            state_d = RUN;
            rem_d   = {1'b0, reg_a_q[2*N-1:N]};
            lo_d    = reg_a_q[N-1:0];
            cnt_d   = '0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        rem_d = step_rem;
        lo_d  = lo_sh[N-1:0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          state_d = DONE;
          q_d     = lo_sh[N-1:0];
          r_d     = step_rem[N-1:0];
          ovf_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      reg_a_q <= '0;
      reg_b_q <= '0;
      rem_q   <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      reg_a_q <= reg_a_d;
      reg_b_q <= reg_b_d;
      rem_q   <= rem_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      ovf_q   <= ovf_d;
    end
  end

  assign q_out = q_q;
  assign r_out = r_q;
  assign ovf   = ovf_q;
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (N=8).
// Overflow expectations follow DIV_OVF_CHECK_EN when defined.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ea = 1'b0;
  logic        eb = 1'b0;
  logic [15:0] data_a = '0;
  logic [7:0]  data_b = '0;
  logic        start = 1'b0;
  logic [7:0]  q_out;
  logic [7:0]  r_out;
  logic        busy;
  logic        done;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_divider #(.N(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .ea     (ea),
    .eb     (eb),
    .data_a (data_a),
    .data_b (data_b),
    .start  (start),
    .q_out  (q_out),
    .r_out  (r_out),
    .busy   (busy),
    .done   (done),
    .ovf    (ovf)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Counts edges from the start edge (inclusive) until done is seen.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic do_op(input logic [15:0] a, input logic [7:0] b,
                       output int lat);
    @(negedge clk);
    ea = 1'b1; eb = 1'b1; data_a = a; data_b = b;
    @(negedge clk);
    ea = 1'b0; eb = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
  endtask

  int lat;
  int nbusy;
  int ndone;
  int t0, t1, t2, cyc;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_q", q_out, 0);
    chk("rst_r", r_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;

    do_op(16'd143, 8'd11, lat);
    chk("a143_lat", lat, 9);
    chk("a143_q", q_out, 13);
    chk("a143_r", r_out, 0);
    chk("a143_ovf", ovf, 0);
    @(negedge clk);
    chk("done_pulse_1cyc", done, 0);

    do_op(16'd100, 8'd7, lat);
    chk("a100_q", q_out, 14);
    chk("a100_r", r_out, 2);

    do_op(16'hFE01, 8'hFF, lat);
    chk("fe01_lat", lat, 9);
    chk("fe01_q", q_out, 255);
    chk("fe01_r", r_out, 0);

    do_op(16'h1234, 8'h00, lat);
`ifdef DIV_OVF_CHECK_EN
    chk("div0_lat", lat, 1);
    chk("div0_q", q_out, 255);
    chk("div0_r", r_out, 0);
    chk("div0_ovf", ovf, 1);
    do_op(16'h0100, 8'h01, lat);
    chk("ovf2_lat", lat, 1);
    chk("ovf2_ovf", ovf, 1);
`else
    chk("div0_lat", lat, 9);
    chk("div0_ovf", ovf, 0);
    do_op(16'h0100, 8'h01, lat);
    chk("ovf2_lat", lat, 9);
    chk("ovf2_ovf", ovf, 0);
`endif
    do_op(16'd100, 8'd7, lat);
    chk("ovf_clr", ovf, 0);
    chk("ovf_clr_q", q_out, 14);

    // start/ea/eb during RUN must be ignored: 200/9 = 22 r 2
    @(negedge clk);
    ea = 1'b1; eb = 1'b1; data_a = 16'd200; data_b = 8'd9;
    @(negedge clk);
    ea = 1'b0; eb = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nbusy = 0;
    ndone = 0;
    for (int i = 0; i < 14; i++) begin
      if (busy) nbusy++;
      if (done) ndone++;
      if (i >= 1 && i <= 5) begin
        start = 1'b1; ea = 1'b1; eb = 1'b1;
        data_a = 16'hFFFF; data_b = 8'd1;
      end else begin
        start = 1'b0; ea = 1'b0; eb = 1'b0;
      end
      @(negedge clk);
    end
    chk("run_busy_cycles", nbusy, 8);
    chk("run_done_count", ndone, 1);
    chk("run_q", q_out, 22);
    chk("run_r", r_out, 2);
    // Registers must still hold 200/9
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    chk("run_regs_q", q_out, 22);
    chk("run_regs_r", r_out, 2);

    // Reset during RUN cycle 4
    do_op(16'd143, 8'd11, lat);
    @(negedge clk);
    ea = 1'b1; eb = 1'b1; data_a = 16'd100; data_b = 8'd7;
    @(negedge clk);
    ea = 1'b0; eb = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_q", q_out, 0);
    chk("abort_r", r_out, 0);
    chk("abort_ovf", ovf, 0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("abort_no_done", ndone, 0);
    do_op(16'd100, 8'd7, lat);
    chk("after_rst_lat", lat, 9);
    chk("after_rst_q", q_out, 14);
    chk("after_rst_r", r_out, 2);

    // Back-to-back with start held
    @(negedge clk);
    ea = 1'b1; eb = 1'b1; data_a = 16'd143; data_b = 8'd11;
    @(negedge clk);
    ea = 1'b0; eb = 1'b0; start = 1'b1;
    t0 = -1; t1 = -1; t2 = -1;
    cyc = 0;
    while (t2 < 0 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        if (t0 < 0) t0 = cyc;
        else if (t1 < 0) t1 = cyc;
        else t2 = cyc;
      end
    end
    start = 1'b0;
    chk("b2b_first", t0, 9);
    chk("b2b_gap1", t1 - t0, 9);
    chk("b2b_gap2", t2 - t1, 9);
    chk("b2b_q", q_out, 13);
    @(negedge clk);
    chk("b2b_idle_busy", busy, 0);
    chk("b2b_idle_done", done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
